// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: stall/flush for load-use, taken branches and slow data memory, plus EX forwarding selects.
// Latency: stall/flush/forward outputs are combinational (same cycle); counters and mem_error update on the clock edge.
// Backpressure: a pending data-memory access (mem_ready low) freezes the whole pipeline until ready, or forever after a timeout.
module hazard_control_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_WIDTH    = 16,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  mem_read_e,
    input  logic                  pc_src_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic                  mem_req_m,
    input  logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_w,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  mem_error,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    localparam int WCW = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WCW-1:0] wait_cnt;
    logic           freeze;
    logic           lw_stall;

    // MEM forwarding wins over WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rdm,
        input logic                  rwm,
        input logic [REG_ADDR_W-1:0] rdw,
        input logic                  rww
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rwm && (rdm != '0) && (rdm == rs)) begin
            sel = 2'b10;
        end else if (rww && (rdw != '0) && (rdw == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // State register for the memory-wait FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait counter: held at zero outside MEM_WAIT so it starts from zero on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state != MEM_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Next state and Mealy freeze; the ready cycle itself is not frozen.
    always_comb begin
        state_nxt = state;
        freeze    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_m && !mem_ready) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ERROR;
                    end
                end
            end
            ERROR: begin
                freeze = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        lw_stall = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    end

    // Stall/flush controls; freeze overrides, and a taken branch cancels the load-use stall.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            stall_f = lw_stall && !pc_src_e;
            stall_d = lw_stall && !pc_src_e;
            flush_d = pc_src_e;
            flush_e = pc_src_e || lw_stall;
        end
    end

    // Forwarding selects for both EX operands, independent of freeze.
    always_comb begin
        forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
        forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
    end

    // Sticky error flag, raised as the FSM moves into ERROR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_error <= 1'b0;
        end else if (state_nxt == ERROR) begin
            mem_error <= 1'b1;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_f && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if ((flush_d || flush_e) && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Generates the stall (hold) and clear (flush) controls for the pipeline registers of the 5-stage RISC-V pipeline, plus forwarding selects for the EX stage.
- Covers three hazard sources:
  - load-use data hazards;
  - taken branches and jumps resolved in EX;
  - multi-cycle data-memory accesses, through a ready handshake with a wait FSM and a timeout.
- Keeps saturating stall and flush event counters for performance analysis.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_WIDTH, 16, width of each performance counter.
- WAIT_TIMEOUT, 64, maximum MEM_WAIT cycles before the error state; legal range 2..2^16-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- rs1_d, rs2_d  input  REG_ADDR_W  source registers of the instruction in ID
- rs1_e, rs2_e, rd_e  input  REG_ADDR_W  source and destination registers in EX
- mem_read_e  input  1  instruction in EX is a load
- pc_src_e  input  1  branch or jump taken in EX
- rd_m  input  REG_ADDR_W  destination register in MEM
- reg_write_m  input  1  MEM instruction writes the register file
- mem_req_m  input  1  MEM instruction accesses data memory
- mem_ready  input  1  data memory completes the access this cycle
- rd_w  input  REG_ADDR_W  destination register in WB
- reg_write_w  input  1  WB instruction writes the register file
- stall_f, stall_d, stall_e, stall_m  output  1  high = PC / IF-ID / ID-EX / EX-MEM register holds its value
- flush_d, flush_e, flush_w  output  1  high = IF-ID / ID-EX / MEM-WB register loads zero on the next edge
- forward_a_e, forward_b_e  output  2  00 = register file, 10 = MEM result, 01 = WB result
- mem_error  output  1  sticky; memory timeout occurred
- stall_count, flush_count  output  CNT_WIDTH  saturating event counters

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; the wait counter is cleared.
  - mem_error=0, stall_count=0, flush_count=0.
  - Every combinational output is driven from the IDLE state.
- FSM states: IDLE, MEM_WAIT, ERROR.
  - IDLE -> MEM_WAIT when mem_req_m=1 and mem_ready=0.
  - MEM_WAIT -> IDLE when mem_ready=1.
  - MEM_WAIT -> ERROR when the wait counter reaches WAIT_TIMEOUT-1 and mem_ready=0.
  - ERROR is held until reset.
- Wait counter: cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle.
- freeze (Mealy):
  - freeze = (IDLE and mem_req_m and not mem_ready), or (MEM_WAIT and not mem_ready), or ERROR.
  - The cycle in which mem_ready=1 is not frozen; the pipeline advances on that edge.
- When freeze=1:
  - stall_f=stall_d=stall_e=stall_m=1, flush_w=1.
  - flush_d=flush_e=0, regardless of load-use or pc_src_e.
- lw_stall = mem_read_e and rd_e!=0 and (rd_e==rs1_d or rd_e==rs2_d).
- When not frozen:
  - stall_f = stall_d = lw_stall and not pc_src_e.
  - flush_d = pc_src_e.
  - flush_e = pc_src_e or lw_stall.
  - stall_e = stall_m = flush_w = 0.
- Branch priority: a taken branch cancels the load-use stall. The ID instruction is wrong-path and is flushed.
- Forwarding (combinational, independent of freeze):
  - forward_a_e = 10 if reg_write_m and rd_m!=0 and rd_m==rs1_e.
  - Otherwise 01 if reg_write_w and rd_w!=0 and rd_w==rs1_e.
  - Otherwise 00.
  - MEM has priority over WB. forward_b_e is the same rule using rs2_e.
- Counters (updated on the clock edge):
  - stall_count +1 in each cycle where stall_f=1.
  - flush_count +1 in each cycle where flush_d or flush_e is 1.
  - Both saturate at all-ones and never wrap.
- mem_error is set on entry to ERROR and cleared only by reset.
- Reset asserted mid-MEM_WAIT aborts the wait immediately; all outputs take their reset values asynchronously.

Test Plan:
- Load-use: mem_read_e=1, rd_e=5, rs2_d=5, pc_src_e=0.
  - Required: stall_f=stall_d=1, flush_e=1 for exactly 1 cycle; stall_count=1.
- Load-use with rd_e=0, rs1_d=0.
  - Required: no stall, no flush.
- Taken branch together with load-use: pc_src_e=1 and the load-use condition true.
  - Required: flush_d=flush_e=1, stall_f=stall_d=0; flush_count increments by 1.
- Memory wait: mem_req_m=1, mem_ready low for 3 cycles, then high.
  - Required: all stalls and flush_w=1 for 3 cycles; released in the ready cycle.
  - Required: FSM back in IDLE; stall_count=3.
- Timeout: WAIT_TIMEOUT=4, mem_ready held 0.
  - Required: ERROR entered, mem_error=1, freeze persists.
  - Then reset=0 mid-freeze. Required: outputs drop asynchronously and the counters read 0.
- Forwarding: rd_m=rd_w=7, rs1_e=7, reg_write_m=reg_write_w=1.
  - Required: forward_a_e=10.
  - With reg_write_m=0: forward_a_e=01.
  - With rd=0: forward_a_e=00.
